microwave_time_entry: RTL and testbench
=======================================

Name: microwave_time_entry

Overview:
- Keypad-side front end for MinutesSecondsTimer: collects up to three BCD digits (m:ss), validates them and loads them into the timer with a one-cycle Load pulse.
- Drives the timer's Enable and Clearn, and consumes its timer_done.
- Adds pause/resume/cancel control and an end-of-cook beep window.
- Sits between the keypad decoder and MinutesSecondsTimer in the Level2 hierarchy.

Parameters:
- BEEP_CYCLES, 3: number of cycles done_beep stays high after timer_done.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Clear  input  1  reset, synchronous, active-high.
- key_valid  input  1  one-cycle strobe; key_code is valid when this is high.
- key_code  input  4  0-9 are digits, 10 is START, 11 is CANCEL, 12-15 are ignored.
- timer_done  input  1  from MinutesSecondsTimer; expiry indication.
- Load  output  1  one-cycle load strobe to the timer.
- Enable  output  1  count enable to the timer.
- timer_clearn  output  1  active-low clear strobe to the timer Clearn.
- initial_seconds_units  output  4  BCD seconds units.
- initial_seconds_tens  output  3  seconds tens, 0-5.
- initial_minutes_units  output  4  BCD minutes units.
- entry_error  output  1  high while in the ERROR state.
- done_beep  output  1  high while in the DONE state.
- busy  output  1  high in LOAD, RUN and PAUSED.

Behaviour:
- Reset: Clear is sampled at the rising edge. While Clear is high, the block is forced to IDLE regardless of state.
  - Digit registers d2, d1, d0 (4 bits each) = 0; digit count = 0.
  - Load = 0, Enable = 0, timer_clearn = 1, entry_error = 0, done_beep = 0, busy = 0.
  - A reset during RUN drops Enable in the same cycle.
- Outputs: all outputs are registered.
  - initial_minutes_units = d2.
  - initial_seconds_tens = d1[2:0].
  - initial_seconds_units = d0.
- Digit entry (IDLE/ENTRY only), on key_valid with a digit key:
  - d2 <= d1, d1 <= d0, d0 <= key; count increments; state goes to ENTRY.
  - When count is 3, further digits are ignored; count saturates.
- States and transitions:
  - IDLE:
    - digit -> ENTRY.
    - START with count 0 -> ignored.
    - CANCEL -> ignored.
  - ENTRY:
    - START with d1 <= 5 -> LOAD.
    - START with d1 > 5 -> ERROR.
    - CANCEL -> IDLE, digits cleared.
  - LOAD (exactly 1 cycle):
    - Load = 1, Enable = 0, then -> RUN.
    - All keys are dropped.
  - RUN (Enable = 1):
    - timer_done -> DONE; Enable is 0 from the next cycle.
    - CANCEL -> PAUSED.
    - Digits and START are ignored.
  - PAUSED (Enable = 0):
    - START -> RUN with no Load pulse, so the timer resumes from its held count.
    - CANCEL -> IDLE: digits cleared, timer_clearn = 0 for exactly one cycle.
    - timer_done is ignored.
  - ERROR:
    - entry_error = 1.
    - Any key -> IDLE with digits cleared; the key itself is consumed and not applied.
  - DONE:
    - done_beep = 1 for BEEP_CYCLES cycles, then -> IDLE with digits cleared.
    - Keys are ignored.
- Latency: START accepted at edge N -> Load high in cycle N+1 -> Enable high from cycle N+2.
- Simultaneous events:
  - timer_done and a key in the same RUN cycle: timer_done wins and the key is dropped.
  - Clear beats everything.
- Keys 12-15 are ignored in every state.
- Internal beep counter is sized as $clog2(BEEP_CYCLES+1) bits.

Decomposition:
- Shared package microwave_pkg holds:
  - state enum IDLE/ENTRY/LOAD/RUN/PAUSED/ERROR/DONE;
  - KEY_START = 4'd10 and KEY_CANCEL = 4'd11;
  - MAX_SEC_TENS = 5.
- One sub-module, bcd_digit_shifter: the 3-digit shift register with saturating count and clear. The FSM stays in the top module.

Test Plan:
- Keys 1,3,0 then START: Load = 1 for one cycle with minutes = 1, tens = 3, units = 0. Enable = 1 from the following cycle; busy = 1.
- Keys 9,9 then START: d1 = 9 > 5, so entry_error = 1 and no Load. Next key 5 returns to IDLE with all digits 0; the 5 is not loaded.
- Keys 1,2,3,4 then START: the 4th digit is ignored and Load presents 1:23. START alone from reset gives no Load and the state stays IDLE.
- Cancel/resume/clear sequence:
  - In RUN, CANCEL gives Enable = 0; START gives Enable = 1 with no Load.
  - CANCEL twice then gives one cycle of timer_clearn = 0, then IDLE with digits 0.
- In RUN, timer_done for one cycle: Enable = 0, then done_beep high for exactly 3 cycles, then IDLE. A START key issued in the same cycle as timer_done is dropped.
- Clear asserted mid-RUN: next cycle Enable = 0, all outputs at reset values, timer_clearn = 1.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad time-entry front end.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        LOAD,
        RUN,
        PAUSED,
        ERROR,
        DONE
    } state_t;

    localparam logic [3:0] KEY_START    = 4'd10;
    localparam logic [3:0] KEY_CANCEL   = 4'd11;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_shifter.sv
// Three-digit BCD entry register: new digits enter at d0 and push older ones left.
module bcd_digit_shifter (
    input  logic       clk,
    input  logic       clear,
    input  logic       shift,
    input  logic [3:0] digit,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    logic [1:0] count;

    // Once three digits are held, further digits are dropped rather than shifting.
    always_ff @(posedge clk) begin
        if (clear) begin
            d2    <= 4'd0;
            d1    <= 4'd0;
            d0    <= 4'd0;
            count <= 2'd0;
        end else if (shift && count != 2'd3) begin
            d2    <= d1;
            d1    <= d0;
            d0    <= digit;
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/microwave_time_entry.sv
// Keypad front end for MinutesSecondsTimer: collects m:ss, validates, loads and
// supervises the timer with pause/resume/cancel and an end-of-cook beep window.
module microwave_time_entry
    import microwave_pkg::*;
#(
    parameter int BEEP_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       timer_done,
    output logic       Load,
    output logic       Enable,
    output logic       timer_clearn,
    output logic [3:0] initial_seconds_units,
    output logic [2:0] initial_seconds_tens,
    output logic [3:0] initial_minutes_units,
    output logic       entry_error,
    output logic       done_beep,
    output logic       busy
);

    localparam int BW = $clog2(BEEP_CYCLES + 1);

    state_t        state;
    state_t        next;
    logic [BW-1:0] beep_cnt;
    logic [3:0]    d2, d1, d0;
    logic          key_digit, key_start, key_cancel, key_any;
    logic          shift_digit, clear_digits;

    assign key_digit  = key_valid && is_digit(key_code);
    assign key_start  = key_valid && key_code == KEY_START;
    assign key_cancel = key_valid && key_code == KEY_CANCEL;
    assign key_any    = key_valid && key_code <= KEY_CANCEL;

    assign shift_digit = key_digit && (state == IDLE || state == ENTRY);

    always_comb begin
        next         = state;
        clear_digits = 1'b0;
        case (state)
            IDLE: begin
                if (key_digit) next = ENTRY;
            end
            ENTRY: begin
                if (key_start) begin
                    next = (d1 <= MAX_SEC_TENS) ? LOAD : ERROR;
                end else if (key_cancel) begin
                    next         = IDLE;
                    clear_digits = 1'b1;
                end
            end
            LOAD: next = RUN;
            // Expiry takes priority over any key arriving in the same cycle.
            RUN: begin
                if (timer_done)      next = DONE;
                else if (key_cancel) next = PAUSED;
            end
            PAUSED: begin
                if (key_start) begin
                    next = RUN;
                end else if (key_cancel) begin
                    next         = IDLE;
                    clear_digits = 1'b1;
                end
            end
            ERROR: begin
                if (key_any) begin
                    next         = IDLE;
                    clear_digits = 1'b1;
                end
            end
            DONE: begin
                if (beep_cnt == BW'(BEEP_CYCLES - 1)) begin
                    next         = IDLE;
                    clear_digits = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
    end

    bcd_digit_shifter u_shifter (
        .clk   (CLK),
        .clear (Clear || clear_digits),
        .shift (shift_digit),
        .digit (key_code),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0)
    );

    assign initial_minutes_units = d2;
    assign initial_seconds_tens  = d1[2:0];
    assign initial_seconds_units = d0;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state        <= IDLE;
            beep_cnt     <= '0;
            Load         <= 1'b0;
            Enable       <= 1'b0;
            timer_clearn <= 1'b1;
            entry_error  <= 1'b0;
            done_beep    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next;
            beep_cnt     <= (state == DONE) ? beep_cnt + 1'b1 : '0;
            Load         <= (next == LOAD);
            Enable       <= (next == RUN);
            timer_clearn <= !(state == PAUSED && next == IDLE);
            entry_error  <= (next == ERROR);
            done_beep    <= (next == DONE);
            busy         <= (next == LOAD || next == RUN || next == PAUSED);
        end
    end

endmodule

// File: tb/tb_microwave_time_entry.sv
// Directed bench for microwave_time_entry with immediate-assertion checks.
module tb_microwave_time_entry;

    logic       CLK = 1'b0;
    logic       Clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_done;
    logic       Load;
    logic       Enable;
    logic       timer_clearn;
    logic [3:0] initial_seconds_units;
    logic [2:0] initial_seconds_tens;
    logic [3:0] initial_minutes_units;
    logic       entry_error;
    logic       done_beep;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    microwave_time_entry #(.BEEP_CYCLES(3)) dut (
        .CLK                   (CLK),
        .Clear                 (Clear),
        .key_valid             (key_valid),
        .key_code              (key_code),
        .timer_done            (timer_done),
        .Load                  (Load),
        .Enable                (Enable),
        .timer_clearn          (timer_clearn),
        .initial_seconds_units (initial_seconds_units),
        .initial_seconds_tens  (initial_seconds_tens),
        .initial_minutes_units (initial_minutes_units),
        .entry_error           (entry_error),
        .done_beep             (done_beep),
        .busy                  (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic chk_time(input string tag, input logic [3:0] m, input logic [2:0] t, input logic [3:0] u);
        chk({tag, "_min"},   {4'd0, initial_minutes_units}, {4'd0, m});
        chk({tag, "_tens"},  {5'd0, initial_seconds_tens},  {5'd0, t});
        chk({tag, "_units"}, {4'd0, initial_seconds_units}, {4'd0, u});
    endtask

    initial begin
        Clear      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        timer_done = 1'b0;
        tick();
        tick();
        chk("rst_load",   Load,         0);
        chk("rst_enable", Enable,       0);
        chk("rst_clearn", timer_clearn, 1);
        chk("rst_err",    entry_error,  0);
        chk("rst_beep",   done_beep,    0);
        chk("rst_busy",   busy,         0);
        chk_time("rst", 0, 0, 0);
        Clear = 1'b0;
        tick();

        // 1:30 load, then expiry with a simultaneous START that must be dropped
        press(4'd1); press(4'd3); press(4'd0);
        chk_time("e130", 1, 3, 0);
        chk("e130_load_pre", Load, 0);
        press(4'd10);
        chk("l130_load",   Load,   1);
        chk("l130_enable", Enable, 0);
        chk("l130_busy",   busy,   1);
        chk_time("l130", 1, 3, 0);
        tick();
        chk("r130_load",   Load,   0);
        chk("r130_enable", Enable, 1);
        chk("r130_busy",   busy,   1);
        timer_done = 1'b1;
        press(4'd10);
        timer_done = 1'b0;
        chk("d_enable", Enable,    0);
        chk("d_beep1",  done_beep, 1);
        chk("d_load",   Load,      0);
        chk("d_busy",   busy,      0);
        tick();
        chk("d_beep2", done_beep, 1);
        tick();
        chk("d_beep3", done_beep, 1);
        tick();
        chk("d_beep_off", done_beep, 0);
        chk("d_idle_en",  Enable,    0);
        chk("d_idle_ld",  Load,      0);
        chk_time("d_idle", 0, 0, 0);

        // 99 then START is invalid; ignored code keeps ERROR, next key clears without applying
        press(4'd9); press(4'd9);
        press(4'd10);
        chk("err_flag", entry_error, 1);
        chk("err_load", Load,        0);
        chk("err_busy", busy,        0);
        press(4'd13);
        chk("err_ign13", entry_error, 1);
        press(4'd5);
        chk("err_exit", entry_error, 0);
        chk_time("err_exit", 0, 0, 0);
        tick();
        chk("err_noload", Load, 0);
        chk_time("err_after", 0, 0, 0);

        // START alone in IDLE does nothing; ignored code in IDLE does not shift
        press(4'd10);
        chk("idle_start_ld",  Load,        0);
        chk("idle_start_bsy", busy,        0);
        chk("idle_start_err", entry_error, 0);
        press(4'd12);
        chk_time("idle_k12", 0, 0, 0);

        // 1,2,3,4: fourth digit dropped, loads 1:23
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk_time("sat", 1, 2, 3);
        press(4'd10);
        chk("sat_load", Load, 1);
        chk_time("sat_load", 1, 2, 3);
        tick();
        chk("sat_run_en", Enable, 1);

        // pause, ignore expiry while paused, resume without Load, then cancel-clear
        press(4'd11);
        chk("pause_en",   Enable, 0);
        chk("pause_busy", busy,   1);
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        chk("pause_done_beep", done_beep, 0);
        chk("pause_done_busy", busy,      1);
        press(4'd10);
        chk("resume_en",   Enable, 1);
        chk("resume_load", Load,   0);
        tick();
        chk("resume_load2", Load, 0);
        press(4'd7);
        chk_time("run_digit", 1, 2, 3);
        press(4'd11);
        chk("pause2_en", Enable, 0);
        chk("pause2_clr", timer_clearn, 1);
        press(4'd11);
        chk("cancel_clearn", timer_clearn, 0);
        chk("cancel_busy",   busy,         0);
        chk_time("cancel", 0, 0, 0);
        tick();
        chk("cancel_clearn_back", timer_clearn, 1);

        // ENTRY cancel clears digits
        press(4'd4); press(4'd2);
        press(4'd11);
        chk_time("ecancel", 0, 0, 0);
        chk("ecancel_busy", busy, 0);

        // Clear during RUN
        press(4'd2);
        press(4'd10);
        tick();
        chk("clr_pre_en", Enable, 1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("clr_enable", Enable,       0);
        chk("clr_load",   Load,         0);
        chk("clr_busy",   busy,         0);
        chk("clr_clearn", timer_clearn, 1);
        chk("clr_err",    entry_error,  0);
        chk("clr_beep",   done_beep,    0);
        chk_time("clr", 0, 0, 0);
        press(4'd7);
        chk_time("clr_after", 0, 0, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
